// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, host FSM state type and pixel-location helper
// for the 512 x 256 monochrome framebuffer controller (fb_ctrl).
//   FB_WIDTH / FB_HEIGHT   frame geometry in pixels
//   FB_DATA_W              RAM word width (= pixels per word)
//   FB_WORDS / FB_ADDR_W   RAM depth and word-address width
//   host_state_t           host read-modify-write FSM states
//   fb_locate()            (x, y) -> word address and bit index
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 512;
    localparam int unsigned FB_HEIGHT = 256;
    localparam int unsigned FB_DATA_W = 16;
    localparam int unsigned FB_WORDS  = (FB_WIDTH * FB_HEIGHT) / FB_DATA_W;
    localparam int unsigned FB_ADDR_W = 13;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        MOD
    } host_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [3:0]           bit_idx;
    } pix_loc_t;

    // Leftmost pixel of a word lives in the MSB.
    function automatic pix_loc_t fb_locate(input logic [8:0] x, input logic [7:0] y);
        pix_loc_t loc;
        loc.addr    = {y, x[8:4]};
        loc.bit_idx = 4'd15 - x[3:0];
        return loc;
    endfunction

endpackage

// File: rtl/fb_ctrl_if.sv
// fb_ctrl_if: signal bundle between fb_ctrl and its surroundings.
//   RAM      : mem_raddr/mem_q (registered read), mem_waddr/mem_d/mem_we
//   video    : vid_sof, vid_next in; vid_pixel, vid_underrun out
//   host     : host_req/x/y/val in; host_ready, host_done out
//   clear    : clear_req in; clear_busy out
// Modports: master = controller side, slave = RAM/video/host side.
interface fb_ctrl_if
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
);

    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_q;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;

    logic              vid_sof;
    logic              vid_next;
    logic              vid_pixel;
    logic              vid_underrun;

    logic              host_req;
    logic [8:0]        host_x;
    logic [7:0]        host_y;
    logic              host_val;
    logic              host_ready;
    logic              host_done;

    logic              clear_req;
    logic              clear_busy;

    modport master (
        output mem_raddr, mem_waddr, mem_d, mem_we,
        input  mem_q,
        input  vid_sof, vid_next,
        output vid_pixel, vid_underrun,
        input  host_req, host_x, host_y, host_val,
        output host_ready, host_done,
        input  clear_req,
        output clear_busy
    );

    modport slave (
        input  mem_raddr, mem_waddr, mem_d, mem_we,
        output mem_q,
        output vid_sof, vid_next,
        input  vid_pixel, vid_underrun,
        output host_req, host_x, host_y, host_val,
        input  host_ready, host_done,
        output clear_req,
        input  clear_busy
    );

endinterface

// File: rtl/fb_scan_buf.sv
// fb_scan_buf: two-word scanout prefetch buffer with 4-bit bit index.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_sof          start of frame: flush, zero index, drop in-flight read
//   i_next         consume one pixel
//   i_issue        a scan read was issued this cycle (data on i_q next cycle)
//   i_q            RAM registered read data
//   o_fetch_req    buffered + in-flight words < 2
//   o_pixel        current pixel (MSB first), 0 when empty
//   o_underrun     i_next while empty
module fb_scan_buf
    import fb_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sof,
    input  logic                 i_next,
    input  logic                 i_issue,
    input  logic [FB_DATA_W-1:0] i_q,
    output logic                 o_fetch_req,
    output logic                 o_pixel,
    output logic                 o_underrun
);

    logic [FB_DATA_W-1:0] r_word0;
    logic [FB_DATA_W-1:0] r_word1;
    logic [1:0]           r_cnt;
    logic [3:0]           r_idx;
    logic                 r_pend;
    logic                 w_adv;
    logic                 w_pop;
    logic                 w_push;

    always_comb begin
        w_adv       = i_next && !i_sof && (r_cnt != 2'd0);
        w_pop       = w_adv && (r_idx == 4'd15);
        // A read returning in the sof cycle belongs to the old frame.
        w_push      = r_pend && !i_sof;
        o_underrun  = !i_rst && i_next && !i_sof && (r_cnt == 2'd0);
        o_pixel     = !i_rst && (r_cnt != 2'd0) && r_word0[4'd15 - r_idx];
        // The sof cycle issues nothing: scan_addr is being reset.
        o_fetch_req = !i_rst && !i_sof && (({1'b0, r_cnt} + {2'b00, r_pend}) < 3'd2);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_sof) begin
            r_word0 <= '0;
            r_word1 <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_pend <= i_issue;
            if (w_adv) begin
                r_idx <= r_idx + 4'd1;
            end
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_word0 <= i_q;
                    end else begin
                        r_word1 <= i_q;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_word0 <= r_word1;
                    r_cnt   <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_word0 <= i_q;
                    end else begin
                        r_word0 <= r_word1;
                        r_word1 <= i_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fb_ctrl.sv
// fb_ctrl: framebuffer RAM controller (8K x 16, 512 x 256 pixels).
//   clk, rst  sole clock; synchronous active-high reset
//   bus       fb_ctrl_if.master: RAM ports, video scanout, host pixel
//             write (read-modify-write), optional frame clear
// Scan prefetch has strict priority on the read port; the host RMW
// uses it otherwise. All outputs are forced to 0 while rst is high.
// Optional feature: define FB_CLEAR_EN to enable the full-frame clear
// engine; otherwise clear_req is ignored and clear_busy is 0.
module fb_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
) (
    input  logic      clk,
    input  logic      rst,
    fb_ctrl_if.master bus
);

    host_state_t       r_state;
    host_state_t       w_state_nxt;
    pix_loc_t          w_loc;
    logic [ADDR_W-1:0] r_h_addr;
    logic [3:0]        r_h_bit;
    logic              r_h_val;
    logic [ADDR_W-1:0] r_scan_addr;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_merged;
    logic              w_scan_req;
    logic              w_host_ready;
    logic              w_host_acc;
    logic              w_host_grant;
    logic              w_host_we;
    logic              w_clr_block;
    logic              w_clr_we;

    fb_scan_buf u_scan (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sof       (bus.vid_sof),
        .i_next      (bus.vid_next),
        .i_issue     (w_scan_req),
        .i_q         (bus.mem_q),
        .o_fetch_req (w_scan_req),
        .o_pixel     (bus.vid_pixel),
        .o_underrun  (bus.vid_underrun)
    );

    assign w_loc = fb_locate(bus.host_x, bus.host_y);

    always_ff @(posedge clk) begin
        if (rst || bus.vid_sof) begin
            r_scan_addr <= '0;
        end else if (w_scan_req) begin
            r_scan_addr <= r_scan_addr + ADDR_W'(1);
        end
    end

    // Host RMW FSM
    always_comb begin
        w_state_nxt  = r_state;
        w_host_ready = 1'b0;
        w_host_acc   = 1'b0;
        w_host_grant = 1'b0;
        w_host_we    = 1'b0;
        case (r_state)
            IDLE: begin
                w_host_ready = !w_clr_block;
                w_host_acc   = bus.host_req && w_host_ready;
                if (w_host_acc) begin
                    w_state_nxt = RD;
                end
            end
            RD: begin
                w_host_grant = !w_scan_req;
                if (w_host_grant) begin
                    w_state_nxt = MOD;
                end
            end
            MOD: begin
                w_host_we   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_h_addr <= '0;
            r_h_bit  <= '0;
            r_h_val  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_host_acc) begin
                r_h_addr <= w_loc.addr;
                r_h_bit  <= w_loc.bit_idx;
                r_h_val  <= bus.host_val;
            end
        end
    end

    always_comb begin
        w_merged          = bus.mem_q;
        w_merged[r_h_bit] = r_h_val;
    end

    // RAM port drive
    always_comb begin
        bus.mem_raddr  = '0;
        bus.mem_waddr  = '0;
        bus.mem_d      = '0;
        bus.mem_we     = 1'b0;
        bus.host_done  = 1'b0;
        bus.host_ready = 1'b0;
        if (!rst) begin
            bus.host_ready = w_host_ready;
            if (w_scan_req) begin
                bus.mem_raddr = r_scan_addr;
            end else if (w_host_grant) begin
                bus.mem_raddr = r_h_addr;
            end
            if (w_host_we) begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = r_h_addr;
                bus.mem_d     = w_merged;
                bus.host_done = 1'b1;
            end else if (w_clr_we) begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = w_clr_addr;
            end
        end
    end

`ifdef FB_CLEAR_EN
    logic              r_clr_busy;
    logic              r_clr_pend;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              w_clr_start;

    // A request arriving mid-RMW is held until the host FSM is back in IDLE.
    assign w_clr_start = (bus.clear_req || r_clr_pend) && !r_clr_busy && (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_busy <= 1'b0;
            r_clr_pend <= 1'b0;
            r_clr_addr <= '0;
        end else if (w_clr_start) begin
            r_clr_busy <= 1'b1;
            r_clr_pend <= 1'b0;
            r_clr_addr <= '0;
        end else if (r_clr_busy) begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
            if (r_clr_addr == ADDR_W'(FB_WORDS - 1)) begin
                r_clr_busy <= 1'b0;
            end
        end else if (bus.clear_req) begin
            r_clr_pend <= 1'b1;
        end
    end

    assign w_clr_block    = r_clr_busy || r_clr_pend || bus.clear_req;
    assign w_clr_we       = r_clr_busy;
    assign w_clr_addr     = r_clr_addr;
    assign bus.clear_busy = r_clr_busy && !rst;
`else
    logic w_unused_clear_req;

    assign w_unused_clear_req = bus.clear_req;
    assign w_clr_block        = 1'b0;
    assign w_clr_we           = 1'b0;
    assign w_clr_addr         = '0;
    assign bus.clear_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_fb_ctrl.sv
// tb_fb_ctrl: self-checking bench for fb_ctrl with a behavioural 8K x 16
// RAM (1-cycle registered read) and a golden shadow of the frame.
// Expected host writes and expected scanout pixels are queued when
// stimulus is driven and checked by a negedge monitor. Honours
// FB_CLEAR_EN when the design is built with it.
module tb_fb_ctrl;
    import fb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_ctrl_if #(.ADDR_W(13), .DATA_W(16)) bus ();

    fb_ctrl #(.ADDR_W(13), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
        int          acc;
    } wr_exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_n   = 0;
    int          under_n = 0;
    bit          pix_en  = 1'b0;
    bit          clr_mode = 1'b0;
    wr_exp_t     wq[$];
    logic        pq[$];
    logic [15:0] ram  [0:8191];
    logic [15:0] gold [0:8191];
    logic        bk_clear;
    logic        bk_we;
    logic [12:0] bk_addr;
    logic [15:0] bk_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RAM model plus a backdoor used only while the design is in reset.
    always @(posedge clk) begin
        if (bk_clear) begin
            for (int i = 0; i < 8192; i++) ram[i] <= '0;
        end else if (bk_we) begin
            ram[bk_addr] <= bk_data;
        end else if (bus.mem_we) begin
            ram[bus.mem_waddr] <= bus.mem_d;
        end
        bus.mem_q <= ram[bus.mem_raddr];
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    wr_exp_t me;
    logic    mpix;
    always @(negedge clk) begin
        if (rst) begin
            check("rst_mem_we", bus.mem_we, 0);
            check("rst_host_ready", bus.host_ready, 0);
            check("rst_outputs", {bus.host_done, bus.vid_pixel, bus.vid_underrun,
                                  bus.clear_busy, bus.mem_raddr}, 0);
        end else begin
            if (bus.mem_we && !clr_mode) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", {bus.mem_waddr, bus.mem_d}, 0);
                end else begin
                    me = wq.pop_front();
                    check("wr_addr", bus.mem_waddr, me.addr);
                    check("wr_data", bus.mem_d, me.data);
                    check("wr_done", bus.host_done, 1);
                    check("wr_latency_le5", (cyc_n - me.acc) <= 5, 1);
                end
            end
            if (bus.host_done && !bus.mem_we) check("done_without_we", bus.mem_we, 1);
            if (bus.vid_underrun) under_n++;
            if (pix_en && bus.vid_next && !bus.vid_sof) begin
                if (bus.vid_underrun) begin
                    check("underrun_pixel", bus.vid_pixel, 0);
                end else if (pq.size() == 0) begin
                    check("pixel_unexpected", 1, 0);
                end else begin
                    mpix = pq.pop_front();
                    check("pixel", bus.vid_pixel, mpix);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [8:0] x, input logic [7:0] y, input logic v,
                              input bit expect_wr);
        int          n;
        wr_exp_t     e;
        logic [12:0] a;
        logic [3:0]  b;
        a = 13'(int'(y) * 32 + int'(x) / 16);
        b = 4'(15 - int'(x) % 16);
        bus.host_req = 1'b1;
        bus.host_x   = x;
        bus.host_y   = y;
        bus.host_val = v;
        n = 0;
        #1;
        while (!bus.host_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (!bus.host_ready) begin
            check("host_accept_timeout", 0, 1);
            bus.host_req = 1'b0;
            return;
        end
        if (expect_wr) begin
            gold[a][b] = v;
            e.addr = a;
            e.data = gold[a];
            e.acc  = cyc_n;
            wq.push_back(e);
        end
        tick();
        bus.host_req = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) pq.push_back(w[i]);
    endtask

    task automatic scan_word0(input string tag);
        int u0;
        u0 = under_n;
        push_word(gold[0]);
        pix_en = 1'b1;
        bus.vid_next = 1'b1;
        repeat (16) tick();
        bus.vid_next = 1'b0;
        tick();
        pix_en = 1'b0;
        check({tag, "_underruns"}, under_n - u0, 0);
        check({tag, "_pix_drained"}, pq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          u0;
        int          busy_n;
        int          bad;
        int          rdy_bad;
        int          nz;
        logic [12:0] exp_a;

        rst = 1'b1;
        bk_clear = 1'b1;
        bk_we = 1'b0;
        bk_addr = '0;
        bk_data = '0;
        bus.vid_sof = 1'b0;
        bus.vid_next = 1'b0;
        bus.host_req = 1'b1;
        bus.host_x = '0;
        bus.host_y = '0;
        bus.host_val = 1'b0;
        bus.clear_req = 1'b0;
        for (int i = 0; i < 8192; i++) gold[i] = '0;
        gold[0] = 16'hA5C3;

        // Reset with preload of word 0
        tick();
        bk_clear = 1'b0;
        bk_we = 1'b1;
        bk_addr = 13'd0;
        bk_data = 16'hA5C3;
        tick();
        bk_we = 1'b0;
        bus.host_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_reset", bus.host_ready, 1);
        tick();

        // Scanout of word 0 after sof
        bus.vid_sof = 1'b1;
        tick();
        bus.vid_sof = 1'b0;
        repeat (3) tick();
        scan_word0("sof_scan");

        // Host writes, including bit/row boundaries and same-word back-to-back
        host_write(9'd17, 8'd2, 1'b1, 1'b1);
        host_write(9'd511, 8'd255, 1'b1, 1'b1);
        host_write(9'd0, 8'd0, 1'b0, 1'b1);
        host_write(9'd2, 8'd0, 1'b0, 1'b1);
        repeat (4) tick();
        check("word65", ram[65], 16'h4000);
        check("word8191", ram[8191], 16'h0001);
        check("word0_rmw", ram[0], 16'h05C3);
        check("wq_drained_1", wq.size(), 0);

        // Continuous scanout alongside continuous host requests
        bus.vid_sof = 1'b1;
        tick();
        bus.vid_sof = 1'b0;
        repeat (3) tick();
        u0 = under_n;
        bus.vid_next = 1'b1;
        for (int i = 0; i < 40; i++) begin
            host_write(9'($urandom_range(511, 0)), 8'($urandom_range(255, 0)),
                       1'($urandom_range(1, 0)), 1'b1);
        end
        bus.vid_next = 1'b0;
        repeat (4) tick();
        check("stream_underruns", under_n - u0, 0);
        check("wq_drained_2", wq.size(), 0);

        // sof with same-cycle next, then next before fill
        u0 = under_n;
        pix_en = 1'b1;
        bus.vid_sof = 1'b1;
        bus.vid_next = 1'b1;
        tick();
        bus.vid_sof = 1'b0;
        #1;
        check("early_next_underrun", bus.vid_underrun, 1);
        tick();
        bus.vid_next = 1'b0;
        pix_en = 1'b0;
        check("sof_underrun_count", under_n - u0, 1);
        repeat (2) tick();
        scan_word0("refill_scan");
        repeat (5) tick();

        // Reset while the RMW is in MOD
        host_write(9'd100, 8'd10, 1'b1, 1'b0);
        check("rmw_rd_addr", bus.mem_raddr, 13'd326);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_mod_reset", bus.host_ready, 1);
        tick();
        check("mod_reset_no_write", ram[326], gold[326]);

`ifdef FB_CLEAR_EN
        clr_mode = 1'b1;
        bus.clear_req = 1'b1;
        #1;
        check("ready_low_on_clear_req", bus.host_ready, 0);
        tick();
        bus.clear_req = 1'b0;
        busy_n = 0;
        bad = 0;
        rdy_bad = 0;
        exp_a = '0;
        for (int k = 0; k < 9000; k++) begin
            bus.clear_req = (k == 100);
            #1;
            if (!bus.clear_busy) break;
            busy_n++;
            if (bus.host_ready) rdy_bad++;
            if (!bus.mem_we || bus.mem_d != 16'h0000 || bus.mem_waddr != exp_a) bad++;
            exp_a = exp_a + 13'd1;
            tick();
        end
        bus.clear_req = 1'b0;
        tick();
        clr_mode = 1'b0;
        nz = 0;
        for (int i = 0; i < 8192; i++) begin
            gold[i] = '0;
            if (ram[i] != 16'h0000) nz++;
        end
        check("clear_busy_cycles", busy_n, 8192);
        check("clear_bad_writes", bad, 0);
        check("clear_ready_high", rdy_bad, 0);
        check("clear_nonzero_words", nz, 0);
`else
        bus.clear_req = 1'b1;
        #1;
        check("clear_ignored_busy", bus.clear_busy, 0);
        tick();
        bus.clear_req = 1'b0;
        #1;
        check("clear_ignored_ready", bus.host_ready, 1);
        check("clear_ignored_we", bus.mem_we, 0);
        busy_n = 0;
        bad = 0;
        rdy_bad = 0;
        nz = 0;
        exp_a = '0;
        tick();
`endif

        // Host path still works after the clear/ignored-clear phase
        host_write(9'd17, 8'd2, 1'b1, 1'b1);
        repeat (4) tick();
        check("post_clear_word65", ram[65], gold[65]);
        check("wq_final", wq.size(), 0);
        check("pq_final", pq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_ctrl.md
# fb_ctrl

Controller for the 8K x 16 black-and-white framebuffer RAM (512 x 256 pixels, 16 pixels per word, one write port, one registered read port).
- Owns both RAM ports and shares the single read port between two requesters: video scanout prefetch and host single-pixel read-modify-write.
- Optionally drives a full-frame clear engine on the write port.
- Sits between the drawing/host logic and the video timing generator.

## Interface
- ADDR_W, 13, RAM word address width (8192 words)
- DATA_W, 16, RAM word width, equal to pixels per word
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_raddr  out  ADDR_W  RAM read address; data appears on mem_q next cycle
- mem_q  in  DATA_W  RAM registered read data
- mem_waddr  out  ADDR_W  RAM write address
- mem_d  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- vid_sof  in  1  start-of-frame pulse; restart scanout at word 0
- vid_next  in  1  consume one pixel, at most one per cycle
- vid_pixel  out  1  current pixel
- vid_underrun  out  1  one-cycle pulse: vid_next while buffer empty
- host_req  in  1  pixel write request
- host_x  in  9  pixel column
- host_y  in  8  pixel row
- host_val  in  1  pixel value to write
- host_ready  out  1  request accepted when host_req && host_ready
- host_done  out  1  one-cycle pulse in the cycle the RAM write is issued
- clear_req  in  1  start full-frame clear (FB_CLEAR_EN only)
- clear_busy  out  1  clear in progress

## Operation
- Pixel mapping:
  - Word address = {host_y, host_x[8:4]}.
  - Bit = 15 - host_x[3:0]; the MSB is the leftmost pixel.
  - Scanout emits words in address order, MSB first.
- Scan buffer:
  - Two-word buffer plus 4-bit bit index.
  - vid_pixel = current word bit (15 - index).
  - vid_next advances the index; at index 15 the word is popped and the index returns to 0.
  - vid_next with the buffer empty: vid_underrun = 1, vid_pixel = 0, no advance.
- Scan fetch:
  - Requested when (buffered words + in-flight reads) < 2.
  - Issues a read of scan_addr, then increments scan_addr; 8191 wraps to 0.
- Read-port arbitration, per cycle: scan fetch has strict priority; the host RMW read takes the port otherwise.
- Host FSM:
  - IDLE: host_ready = 1; accept captures x/y/val, go to RD.
  - RD: drive mem_raddr = word address when the port is granted, go to MOD; otherwise hold in RD.
  - MOD: mem_q valid; drive mem_we = 1, mem_waddr = word, mem_d = mem_q with the target bit replaced by val; host_done = 1; go to IDLE.
- vid_sof:
  - Flushes the buffer, zeroes the bit index, sets scan_addr = 0.
  - Marks any in-flight scan read as discarded.
  - Takes priority over a same-cycle vid_next; that vid_next is ignored, with no underrun.
- Host write landing on a word already prefetched: the buffered copy is stale; this tear is accepted until the next frame.

## Timing
- RAM read latency is 1 cycle.
- Host RMW occupies 3 cycles minimum (IDLE accept, RD, MOD); sustained throughput is 1 pixel / 3 cycles.
- Back-to-back RMW to the same word is hazard-free: the next read is issued at least 1 cycle after the write edge.
- Scan fetch takes at most 2 read slots per 16 vid_next pulses, so the host waits at most 2 cycles in RD.
- After vid_sof, the first pixel is valid 2 cycles later: fetch issued in the cycle after sof, data captured the cycle after that.
- Reset, while rst is high:
  - All outputs are 0; mem_we is gated by !rst, so an RMW in MOD is aborted without writing.
  - Scan buffer is emptied; FSM returns to IDLE.
- host_ready = 1 from the first cycle after rst deasserts.

## Configuration
- FB_CLEAR_EN defined:
  - clear_req starts a clear, writing 0 to addresses 0..8191, one per cycle; takes 8192 cycles.
  - clear_busy = 1 throughout; host_ready = 0 throughout.
  - A pending host RMW finishes before the clear starts.
  - Scan fetch continues during the clear.
  - clear_req while busy is ignored; rst aborts the clear.
- FB_CLEAR_EN undefined: clear_req is ignored and clear_busy is tied to 0.

## Structure
- Package fb_pkg holds:
  - FB_WIDTH = 512, FB_HEIGHT = 256, FB_WORDS = 8192
  - Host FSM state enum (IDLE, RD, MOD)
  - Word-address/bit-index helper function
- One sub-module, fb_scan_buf: two-word buffer, bit index, underrun detection, and sof flush with in-flight discard.

## Test plan
- Reset, preload RAM word 0 = 16'hA5C3, pulse vid_sof, then 16 vid_next -> vid_pixel sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; no underrun.
- Host write x=17, y=2, val=1 over word 16'h0000 -> mem_we at addr 65 with mem_d = 16'h4000; host_done in that same cycle.
- vid_next every cycle alongside continuous host_req -> no underrun; every host request completes within 5 cycles of acceptance.
- vid_next immediately after vid_sof, before fill -> vid_underrun pulse, vid_pixel = 0; the next pixel after fill is bit 15 of word 0.
- Assert rst while FSM is in MOD -> no write occurs; host_ready = 1 the cycle after rst drops.
- FB_CLEAR_EN: clear_req -> clear_busy high for exactly 8192 cycles, every address written 0, host_ready low throughout.
